// File: rtl/sram_mem_ctrl_if.sv
// Bus bundle between the MEM stage, the SRAM controller and the external 16-bit SRAM.
// The slave modport is the controller's view; the master modport is the CPU/SRAM side.
interface sram_mem_ctrl_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller splitting 32-bit loads/stores into two 16-bit SRAM phases
// (low half, then high half), stalling the pipeline through ready until done.
module sram_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter logic [31:0] MEM_BASE    = 32'd1024
) (
    input  logic           clk,
    input  logic           rst,
    sram_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic        op_wr;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] read_data_q;
    logic [31:0] offset;
    logic [16:0] word_idx;
    logic        phase_end;
    logic        req;
    logic        unused_offset;

    assign req           = bus.rd_en | bus.wr_en;
    assign offset        = addr_q - MEM_BASE;
    assign word_idx      = offset[18:2];
    assign unused_offset = ^{offset[31:19], offset[1:0]};
    assign phase_end     = (cnt == LAST_CNT);
    assign bus.read_data = read_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_wr       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            read_data_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        op_wr  <= bus.wr_en;
                        addr_q <= bus.address;
                        data_q <= bus.write_data;
                    end
                end
                LOW, HIGH: begin
                    // Counter wraps to zero on the last cycle so the next phase starts clean.
                    cnt <= phase_end ? '0 : cnt + 4'd1;
                    if (!op_wr && phase_end) begin
                        if (state == LOW)
                            read_data_q[15:0] <= bus.sram_dq_in;
                        else
                            read_data_q[31:16] <= bus.sram_dq_in;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req) state_next = LOW;
            LOW:  if (phase_end) state_next = HIGH;
            HIGH: if (phase_end) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ready       = 1'b0;
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;
        case (state)
            IDLE: bus.ready = ~req;
            LOW: begin
                bus.sram_addr   = {word_idx, 1'b0};
                bus.sram_we_n   = ~op_wr;
                bus.sram_dq_oe  = op_wr;
                bus.sram_dq_out = op_wr ? data_q[15:0] : '0;
            end
            HIGH: begin
                bus.sram_addr   = {word_idx, 1'b1};
                bus.sram_we_n   = ~op_wr;
                bus.sram_dq_oe  = op_wr;
                bus.sram_dq_out = op_wr ? data_q[31:16] : '0;
            end
            DONE: bus.ready = 1'b1;
            default: bus.ready = 1'b0;
        endcase
        // During reset the FSM is about to be IDLE, so ready already reflects that.
        if (rst)
            bus.ready = ~req;
    end
endmodule

// File: doc/sram_mem_ctrl.md
SRAM_MEM_CTRL -- requirements
Module: sram_mem_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 3, SRAM cycles held per half-word phase (legal 1..15).
REQ-002 SHALL have parameter MEM_BASE, default 1024, byte address mapped to SRAM half-word 0.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rd_en  input  1  MEM-stage load request.
REQ-006 wr_en  input  1  MEM-stage store request.
REQ-007 address  input  32  byte address from EX/MEM register (ALU result).
REQ-008 write_data  input  32  store data (Rm value after forwarding).
REQ-009 read_data  output  32  registered load result to MEM/WB register.
REQ-010 ready  output  1  high = MEM stage may advance; low = freeze all pipeline registers.
REQ-011 sram_addr  output  18  SRAM half-word address.
REQ-012 sram_dq_out  output  16  SRAM write data.
REQ-013 sram_dq_oe  output  1  drive enable for sram_dq_out.
REQ-014 sram_dq_in  input  16  SRAM read data.
REQ-015 sram_we_n  output  1  SRAM write strobe, active-low.

Function
REQ-016 SHALL implement FSM states IDLE, LOW, HIGH, DONE.
REQ-017 IDLE with wr_en or rd_en high SHALL latch op, address, write_data and go to LOW next cycle; wr_en SHALL win when both high.
REQ-018 Latched values SHALL be used for the whole access; request/input changes after latch SHALL be ignored.
REQ-019 Offset = (latched address - MEM_BASE) mod 2^32; word index = offset[18:2]; offset[1:0] ignored.
REQ-020 LOW phase: sram_addr = {word index, 0}; HIGH phase: sram_addr = {word index, 1}.
REQ-021 Each of LOW and HIGH SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit counter cleared on each phase entry.
REQ-022 Write LOW: sram_dq_out = data[15:0]; write HIGH: data[31:16]; sram_we_n = 0 and sram_dq_oe = 1 throughout both phases.
REQ-023 Read: sram_we_n = 1, sram_dq_oe = 0; sram_dq_in SHALL be sampled on the last LOW cycle into read_data[15:0] and on the last HIGH cycle into read_data[31:16].
REQ-024 After HIGH, FSM SHALL enter DONE for exactly one cycle, then IDLE unconditionally (no re-trigger from still-asserted request in DONE).
REQ-025 ready = 1 in DONE, and in IDLE when rd_en = wr_en = 0; ready = 0 otherwise (combinational).
REQ-026 Latency: request in IDLE at cycle 0 -> ready high at cycle 2*WAIT_CYCLES+1.
REQ-027 Back-to-back requests: next request SHALL be accepted in the IDLE cycle following DONE.
REQ-028 read_data SHALL hold its last value through writes and idle cycles; only a read updates it.
REQ-029 Outside LOW/HIGH: sram_we_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_out = 0.

Reset
REQ-030 rst high at a clock edge SHALL force IDLE, counter 0, read_data = 0, latched op/address/data = 0, from any state.
REQ-031 Reset mid-access SHALL abort it: sram_we_n = 1, sram_dq_oe = 0 from the reset edge; no partial read_data update.
REQ-032 With rst high, ready SHALL follow REQ-025 as for IDLE.

Verification (WAIT_CYCLES = 3, MEM_BASE = 1024)
REQ-033 wr_en=1, address=1024, write_data=0x12345678 at cycle 0 -> cycles 1-3 addr 0 / dq 0x5678 / we_n 0; cycles 4-6 addr 1 / dq 0x1234; ready 1 only at cycle 7.
REQ-034 SRAM model holds half-word 2=0xBEEF, 3=0xDEAD; rd_en=1, address=1028 -> read_data=0xDEADBEEF, ready 1 at cycle 7, read_data unchanged by a later write.
REQ-035 rd_en=wr_en=0 for 10 cycles -> ready 1, we_n 1, oe 0 every cycle.
REQ-036 rd_en=wr_en=1, address=1032 -> write executed to half-words 4/5, read_data unchanged.
REQ-037 rst asserted at cycle 4 of a write -> cycle 5 IDLE, we_n 1, oe 0, read_data 0; with rd_en=wr_en=0, ready 1.
REQ-038 Two reads held back-to-back (addresses 1024, 1028) -> ready pulses at cycles 7 and 15, read_data correct after each.
